// File: rtl/alu_op_sequencer_pkg.sv
// Shared opcodes, flag bit positions and FSM encoding
// for the ALU operation sequencer.
package alu_op_sequencer_pkg;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_AND   = 4'b0001;
    localparam logic [3:0] OP_OR    = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_ADD   = 4'b0101;
    localparam logic [3:0] OP_LSH   = 4'b1000;
    localparam logic [3:0] OP_SUB   = 4'b1001;
    localparam logic [3:0] OP_CMP   = 4'b1011;
    localparam logic [3:0] OP_MOV   = 4'b1101;

    localparam int FLAG_C = 4;
    localparam int FLAG_L = 3;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic [3:0] eff_op(input logic [3:0] opcode,
                                          input logic [3:0] opext);
        return (opcode != OP_RTYPE) ? opcode : opext;
    endfunction

endpackage

// File: rtl/alu_op_sequencer_alu_core.sv
// Single-cycle combinational ALU: result, next flags and
// an illegal indication for the effective opcode.
module alu_core
    import alu_op_sequencer_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       flags_in,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       flags,
    output logic             illegal
);

    localparam int M = WIDTH - 1;

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result  = '0;
        flags   = flags_in;
        illegal = 1'b0;
        case (op)
            OP_ADD: begin
                result        = sum[M:0];
                flags[FLAG_C] = sum[WIDTH];
                flags[FLAG_F] = (a[M] == b[M]) && (sum[M] != a[M]);
            end
            OP_SUB: begin
                // diff[WIDTH] is the unsigned borrow
                result        = diff[M:0];
                flags[FLAG_C] = diff[WIDTH];
                flags[FLAG_F] = (a[M] != b[M]) && (diff[M] != a[M]);
            end
            OP_AND: result = a & b;
            OP_XOR: result = a ^ b;
            OP_OR:  result = a | b;
            OP_CMP: begin
                result        = a;
                flags[FLAG_L] = a < b;
                flags[FLAG_N] = $signed(a) < $signed(b);
                flags[FLAG_Z] = a == b;
            end
            OP_MOV: result = b;
            OP_LSH: result = a;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// ALU operation sequencer: accepts one op at a time, runs
// multi-cycle shifts and holds the result until consumed.
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [3:0]       opext,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       flags,
    output logic             illegal
);

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       op;
    logic             accept;
    logic             is_lsh;
    logic [WIDTH-1:0] mag;
    logic [CNT_W-1:0] k;
    logic [CNT_W-1:0] cnt;
    logic             dir;
    logic [WIDTH-1:0] core_result;
    logic [4:0]       core_flags;
    logic             core_illegal;

    assign op        = eff_op(opcode, opext);
    assign in_ready  = state == ST_IDLE;
    assign out_valid = state == ST_DONE;
    assign accept    = in_valid && in_ready;
    assign is_lsh    = op == OP_LSH;

    // Most negative b negates to itself, which still saturates to WIDTH
    assign mag = b[WIDTH-1] ? (~b + 1'b1) : b;
    assign k   = (mag >= WIDTH'(WIDTH)) ? CNT_W'(WIDTH) : mag[CNT_W-1:0];

    alu_core #(.WIDTH(WIDTH)) u_core (
        .op       (op),
        .a        (a),
        .b        (b),
        .flags_in (flags),
        .result   (core_result),
        .flags    (core_flags),
        .illegal  (core_illegal)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = (is_lsh && k != '0) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (cnt == CNT_W'(1)) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result  <= '0;
            flags   <= '0;
            illegal <= 1'b0;
            cnt     <= '0;
            dir     <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        result  <= core_result;
                        flags   <= core_flags;
                        illegal <= core_illegal;
                        cnt     <= is_lsh ? k : '0;
                        dir     <= b[WIDTH-1];
                    end
                end
                ST_SHIFT: begin
                    result <= dir ? (result >> 1) : (result << 1);
                    cnt    <= cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomised scoreboard bench for alu_op_sequencer with an
// arithmetic reference model, plus directed corner cases.
module tb_alu_op_sequencer;

    localparam int W = 16;

    logic         clk = 0;
    logic         reset = 1;
    logic         in_valid = 0;
    logic         in_ready;
    logic [3:0]   opcode = 0;
    logic [3:0]   opext = 0;
    logic [W-1:0] a = 0;
    logic [W-1:0] b = 0;
    logic [W-1:0] result;
    logic         out_valid;
    logic         out_ready = 0;
    logic [4:0]   flags;
    logic         illegal;

    alu_op_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .opext     (opext),
        .a         (a),
        .b         (b),
        .result    (result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .flags     (flags),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic [4:0]   flg;
        logic         ill;
        int           acc;
        int           lat;
        int           hold;
    } exp_t;

    exp_t       q[$];
    logic [4:0] mflags = 0;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: flags {C,L,F,Z,N} as plain integer arithmetic
    task automatic model(input logic [3:0] oc, input logic [3:0] ex,
                         input logic [W-1:0] av, input logic [W-1:0] bv,
                         output exp_t e);
        int ua, ub, sa, sb, r, k, s;
        logic [3:0] op;
        ua = int'(av);
        ub = int'(bv);
        sa = (ua >= 32768) ? ua - 65536 : ua;
        sb = (ub >= 32768) ? ub - 65536 : ub;
        op = (oc != 0) ? oc : ex;
        e.ill = 0;
        e.lat = 1;
        r = 0;
        case (op)
            4'd5: begin
                r = ua + ub;
                s = sa + sb;
                mflags[4] = r > 65535;
                mflags[2] = (s > 32767) || (s < -32768);
            end
            4'd9: begin
                r = ua - ub;
                s = sa - sb;
                mflags[4] = ua < ub;
                mflags[2] = (s > 32767) || (s < -32768);
            end
            4'd1: r = ua & ub;
            4'd3: r = ua ^ ub;
            4'd2: r = ua | ub;
            4'd11: begin
                r = ua;
                mflags[3] = ua < ub;
                mflags[0] = sa < sb;
                mflags[1] = ua == ub;
            end
            4'd13: r = ub;
            4'd8: begin
                k = (sb < 0) ? -sb : sb;
                if (k > W) k = W;
                r = (sb > 0) ? (ua << k) : (ua >> k);
                e.lat = 1 + k;
            end
            default: begin
                r = 0;
                e.ill = 1;
            end
        endcase
        e.res = r[W-1:0];
        e.flg = mflags;
    endtask

    task automatic issue(input logic [3:0] oc, input logic [3:0] ex,
                         input logic [W-1:0] av, input logic [W-1:0] bv,
                         input int hold);
        int n = 0;
        exp_t e;
        @(negedge clk);
        // Busy cycles carry junk requests that must be ignored
        while (!in_ready && n < 200) begin
            in_valid = 1'($urandom);
            opcode = 4'($urandom);
            opext = 4'($urandom);
            a = W'($urandom);
            b = W'($urandom);
            n++;
            @(negedge clk);
        end
        check("issue_ready_timeout", int'(in_ready), 1);
        if (!in_ready) begin
            in_valid = 0;
            return;
        end
        opcode = oc;
        opext = ex;
        a = av;
        b = bv;
        in_valid = 1;
        model(oc, ex, av, bv, e);
        e.acc = cyc;
        e.hold = hold;
        q.push_back(e);
        @(posedge clk);
        #1 in_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() > 0 || out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", q.size(), 0);
    endtask

    // Monitor: pops one expectation per DONE episode, checks every DONE cycle
    initial begin
        exp_t cur;
        bit   active = 0;
        bit   want_ready = 0;
        int   held = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                active = 0;
                want_ready = 0;
                out_ready = 0;
                continue;
            end
            if (want_ready) begin
                check("in_ready_after_done", int'(in_ready), 1);
                want_ready = 0;
            end
            if (out_valid) begin
                if (!active) begin
                    if (q.size() == 0) begin
                        check("unexpected_out_valid", 1, 0);
                        out_ready = 1;
                        continue;
                    end
                    cur = q.pop_front();
                    active = 1;
                    held = 0;
                    check("latency", cyc - cur.acc, cur.lat);
                end
                check("result", int'(result), int'(cur.res));
                check("flags", int'(flags), int'(cur.flg));
                check("illegal", int'(illegal), int'(cur.ill));
                check("in_ready_in_done", int'(in_ready), 0);
                held++;
                out_ready = (held > cur.hold);
                want_ready = out_ready;
            end else begin
                active = 0;
                out_ready = 0;
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        logic [3:0] oc, ex;
        logic [W-1:0] bv;
        repeat (3) @(negedge clk);
        reset = 0;
        @(negedge clk);
        check("rst_result", int'(result), 0);
        check("rst_flags", int'(flags), 0);
        check("rst_illegal", int'(illegal), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 1);

        issue(4'h0, 4'h5, 16'h7FFF, 16'h0001, 0);
        issue(4'h9, 4'h0, 16'h0000, 16'h0001, 0);
        issue(4'h0, 4'hB, 16'h0005, 16'hFFFF, 0);
        issue(4'h8, 4'h0, 16'h0001, 16'h0004, 0);
        issue(4'h0, 4'h8, 16'h8000, 16'hFFFD, 0);
        issue(4'h8, 4'h0, 16'h1234, 16'h8000, 0);
        issue(4'h8, 4'h0, 16'hABCD, 16'h0000, 0);
        issue(4'h8, 4'h0, 16'hFFFF, 16'h0010, 0);
        issue(4'h5, 4'h0, 16'h1234, 16'h4321, 3);
        issue(4'h0, 4'h0, 16'h1111, 16'h2222, 0);
        issue(4'h3, 4'h0, 16'h0F0F, 16'hFFFF, 0);
        drain();

        // Reset on the third cycle of a 10-bit shift
        issue(4'h8, 4'h0, 16'h00F0, 16'd10, 0);
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1;
        #1;
        check("mid_rst_result", int'(result), 0);
        check("mid_rst_flags", int'(flags), 0);
        check("mid_rst_illegal", int'(illegal), 0);
        check("mid_rst_out_valid", int'(out_valid), 0);
        q.delete();
        mflags = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check("no_valid_after_rst", int'(seen), 0);
        issue(4'h0, 4'hF, 16'h1234, 16'h5678, 0);
        drain();

        repeat (250) begin
            oc = ($urandom % 3 == 0) ? 4'h0 : 4'($urandom);
            ex = 4'($urandom);
            if ($urandom % 3 == 0) bv = W'($urandom_range(40) - 20);
            else bv = W'($urandom);
            issue(oc, ex, W'($urandom), bv, int'($urandom % 4));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
